// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one single-port SRAM between the boot-loader write port,
//             the core data port and the core instruction-fetch port. At most
//             one SRAM access is issued per cycle. Each response is returned
//             to its owner exactly one cycle after the grant, and accesses
//             outside the SRAM window are flagged with err.
//  Ports    : Clk, Rst             - clock, synchronous active-high reset
//             boot_/data_/instr_*  - req/gnt/rvalid requester ports
//                                    (we, be, addr, wdata in; rdata, err out)
//             mem_*                - SRAM macro port (word-indexed address,
//                                    read data returned one cycle after mem_req)
//  Config   : ARB_ROUND_ROBIN_EN   - when defined, data and instr alternate
//                                    on contention; otherwise data always
//                                    beats instr
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int             AW       = 32,
    parameter int             DW       = 32,
    parameter logic [AW-1:0]  MEM_BASE = 32'h0000_0000,
    parameter int             MEM_SIZE = 4096
) (
    input  logic              Clk,
    input  logic              Rst,

    input  logic              boot_req,
    output logic              boot_gnt,
    output logic              boot_rvalid,
    input  logic              boot_we,
    input  logic [DW/8-1:0]   boot_be,
    input  logic [AW-1:0]     boot_addr,
    input  logic [DW-1:0]     boot_wdata,
    output logic [DW-1:0]     boot_rdata,
    output logic              boot_err,

    input  logic              data_req,
    output logic              data_gnt,
    output logic              data_rvalid,
    input  logic              data_we,
    input  logic [DW/8-1:0]   data_be,
    input  logic [AW-1:0]     data_addr,
    input  logic [DW-1:0]     data_wdata,
    output logic [DW-1:0]     data_rdata,
    output logic              data_err,

    input  logic              instr_req,
    output logic              instr_gnt,
    output logic              instr_rvalid,
    input  logic              instr_we,
    input  logic [DW/8-1:0]   instr_be,
    input  logic [AW-1:0]     instr_addr,
    input  logic [DW-1:0]     instr_wdata,
    output logic [DW-1:0]     instr_rdata,
    output logic              instr_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [AW-3:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    localparam logic [1:0]    c_own_boot  = 2'd0;
    localparam logic [1:0]    c_own_data  = 2'd1;
    localparam logic [1:0]    c_own_instr = 2'd2;
    localparam logic [AW-1:0] c_mem_size  = AW'(MEM_SIZE);

    logic              w_gnt_boot;
    logic              w_gnt_data;
    logic              w_gnt_instr;
    logic              w_any_gnt;
    logic [1:0]        w_sel_owner;
    logic              w_sel_we;
    logic [DW/8-1:0]   w_sel_be;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic [AW:0]       w_diff;
    logic              w_in_range;
    logic              w_resp_vld;

    logic              r_resp_vld;
    logic [1:0]        r_resp_owner;
    logic              r_resp_err;
    logic              r_resp_rd;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 after a data grant (instr wins next contention), 0 after an instr
    // grant; reset value favours data.
    logic              r_prefer_instr;
`endif

    // ------------------------------------------------------------------
    // Grant selection: boot is absolute; data/instr resolved by config.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_boot  = 1'b0;
        w_gnt_data  = 1'b0;
        w_gnt_instr = 1'b0;
        if (!Rst) begin
            if (boot_req) begin
                w_gnt_boot = 1'b1;
            end else if (data_req && instr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (r_prefer_instr) begin
                    w_gnt_instr = 1'b1;
                end else begin
                    w_gnt_data = 1'b1;
                end
`else
                w_gnt_data = 1'b1;
`endif
            end else if (data_req) begin
                w_gnt_data = 1'b1;
            end else if (instr_req) begin
                w_gnt_instr = 1'b1;
            end
        end
    end

    assign w_any_gnt = w_gnt_boot | w_gnt_data | w_gnt_instr;

    // Winner's request fields.
    always_comb begin
        w_sel_owner = c_own_boot;
        w_sel_we    = boot_we;
        w_sel_be    = boot_be;
        w_sel_addr  = boot_addr;
        w_sel_wdata = boot_wdata;
        if (w_gnt_data) begin
            w_sel_owner = c_own_data;
            w_sel_we    = data_we;
            w_sel_be    = data_be;
            w_sel_addr  = data_addr;
            w_sel_wdata = data_wdata;
        end else if (w_gnt_instr) begin
            w_sel_owner = c_own_instr;
            w_sel_we    = instr_we;
            w_sel_be    = instr_be;
            w_sel_addr  = instr_addr;
            w_sel_wdata = instr_wdata;
        end
    end

    // One extra bit catches the borrow when addr < MEM_BASE, so a single
    // subtraction gives both the window check and the SRAM offset.
    assign w_diff     = {1'b0, w_sel_addr} - {1'b0, MEM_BASE};
    assign w_in_range = ~w_diff[AW] && (w_diff[AW-1:0] < c_mem_size);

    assign mem_req   = w_any_gnt & w_in_range;
    assign mem_we    = mem_req & w_sel_we;
    assign mem_be    = mem_req ? w_sel_be : '0;
    assign mem_addr  = w_diff[AW-1:2];
    assign mem_wdata = w_sel_wdata;

    // ------------------------------------------------------------------
    // Response pipeline: reloaded from the grant every cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_resp_vld   <= 1'b0;
            r_resp_owner <= c_own_boot;
            r_resp_err   <= 1'b0;
            r_resp_rd    <= 1'b0;
        end else begin
            r_resp_vld   <= w_any_gnt;
            r_resp_owner <= w_sel_owner;
            r_resp_err   <= w_any_gnt & ~w_in_range;
            r_resp_rd    <= w_any_gnt & w_in_range & ~w_sel_we;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_prefer_instr <= 1'b0;
        end else if (w_gnt_data) begin
            r_prefer_instr <= 1'b1;
        end else if (w_gnt_instr) begin
            r_prefer_instr <= 1'b0;
        end
    end
`endif

    // A response registered just before Rst rises must not escape.
    assign w_resp_vld = r_resp_vld & ~Rst;

    assign boot_gnt    = w_gnt_boot;
    assign data_gnt    = w_gnt_data;
    assign instr_gnt   = w_gnt_instr;

    assign boot_rvalid  = w_resp_vld && (r_resp_owner == c_own_boot);
    assign data_rvalid  = w_resp_vld && (r_resp_owner == c_own_data);
    assign instr_rvalid = w_resp_vld && (r_resp_owner == c_own_instr);

    assign boot_err    = boot_rvalid  & r_resp_err;
    assign data_err    = data_rvalid  & r_resp_err;
    assign instr_err   = instr_rvalid & r_resp_err;

    assign boot_rdata  = (boot_rvalid  && r_resp_rd) ? mem_rdata : '0;
    assign data_rdata  = (data_rvalid  && r_resp_rd) ? mem_rdata : '0;
    assign instr_rdata = (instr_rvalid && r_resp_rd) ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter. Directed stimulus checks
//             grants and SRAM strobes in the grant cycle and queues the
//             expected response; a monitor pops and compares on every rvalid.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;

    logic        boot_req,  boot_gnt,  boot_rvalid,  boot_we,  boot_err;
    logic [3:0]  boot_be;
    logic [31:0] boot_addr, boot_wdata, boot_rdata;
    logic        data_req,  data_gnt,  data_rvalid,  data_we,  data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        instr_req, instr_gnt, instr_rvalid, instr_we, instr_err;
    logic [3:0]  instr_be;
    logic [31:0] instr_addr, instr_wdata, instr_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 Clk = ~Clk;

    ram_arbiter #(
        .AW(AW), .DW(DW), .MEM_BASE(32'h0000_0000), .MEM_SIZE(4096)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .boot_req(boot_req), .boot_gnt(boot_gnt), .boot_rvalid(boot_rvalid),
        .boot_we(boot_we), .boot_be(boot_be), .boot_addr(boot_addr),
        .boot_wdata(boot_wdata), .boot_rdata(boot_rdata), .boot_err(boot_err),
        .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_err(data_err),
        .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid),
        .instr_we(instr_we), .instr_be(instr_be), .instr_addr(instr_addr),
        .instr_wdata(instr_wdata), .instr_rdata(instr_rdata), .instr_err(instr_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural SRAM: 1 KiW, read data one cycle after mem_req.
    logic [31:0] ram [0:1023];
    always @(posedge Clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[9:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[9:0]];
            end
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge Clk) cyc++;

    typedef struct {
        int          owner;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor.
    always @(negedge Clk) begin
        exp_t        e;
        logic [2:0]  rv;
        logic [31:0] own_rd, oth_rd;
        logic        own_err;
        rv = {instr_rvalid, data_rvalid, boot_rvalid};
        if (rv != 3'b000) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rvalid: got rvalid=%b expected none (cycle %0d)", rv, cyc);
            end else begin
                e = sb.pop_front();
                case (e.owner)
                    0:       begin own_rd = boot_rdata;  own_err = boot_err;  oth_rd = data_rdata | instr_rdata; end
                    1:       begin own_rd = data_rdata;  own_err = data_err;  oth_rd = boot_rdata | instr_rdata; end
                    default: begin own_rd = instr_rdata; own_err = instr_err; oth_rd = boot_rdata | data_rdata;  end
                endcase
                chk("resp_owner", 32'(rv), 32'(3'b001 << e.owner));
                chk("resp_err", 32'(own_err), 32'(e.err));
                chk("resp_rdata", own_rd, e.rdata);
                chk("resp_other_rdata", oth_rd, 32'h0);
                chk("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_rvalid: got no rvalid expected owner %0d (cycle %0d)", e.owner, cyc);
        end
    end

    // One grant cycle: eg = {instr,data,boot} expected grants; own < 0 means
    // no response is expected for this cycle.
    task automatic step(input string name, input logic [2:0] eg, input logic emreq,
                        input logic [29:0] emaddr, input logic ewe, input logic [3:0] ebe,
                        input int own, input logic eerr, input logic [31:0] erd);
        @(negedge Clk);
        chk({name, "_gnt"}, 32'({instr_gnt, data_gnt, boot_gnt}), 32'(eg));
        chk({name, "_mem_req"}, 32'(mem_req), 32'(emreq));
        if (emreq) begin
            chk({name, "_mem_addr"}, 32'(mem_addr), 32'(emaddr));
            chk({name, "_mem_we"}, 32'(mem_we), 32'(ewe));
            chk({name, "_mem_be"}, 32'(mem_be), 32'(ebe));
        end
        if (own >= 0) sb.push_back('{own, eerr, erd, cyc + 1});
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_rvalid"}, 32'({instr_rvalid, data_rvalid, boot_rvalid}), 32'h0);
        chk({name, "_err"}, 32'({instr_err, data_err, boot_err}), 32'h0);
        chk({name, "_rdata"}, boot_rdata | data_rdata | instr_rdata, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | 32'(i);
        ram[4] = 32'hDEAD_BEEF;

        boot_req  = 0; boot_we  = 0; boot_be  = 4'hF; boot_addr  = '0; boot_wdata  = '0;
        data_req  = 1; data_we  = 0; data_be  = 4'hF; data_addr  = 32'h20; data_wdata = '0;
        instr_req = 1; instr_we = 0; instr_be = 4'hF; instr_addr = 32'h30; instr_wdata = '0;

        // Reset held with requests pending: nothing granted, nothing returned.
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("reset_gnt", 32'({instr_gnt, data_gnt, boot_gnt}), 32'h0);
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk_quiet("reset");
        @(posedge Clk); #1;
        Rst = 0; data_req = 0; instr_req = 0;

        // Single instruction fetch.
        instr_req = 1; instr_addr = 32'h10;
        step("instr_rd", 3'b100, 1, 30'd4, 0, 4'hF, 2, 0, 32'hDEAD_BEEF);

        // Continuous data + instr contention.
        data_req = 1; data_addr = 32'h20; instr_addr = 32'h30;
`ifdef ARB_ROUND_ROBIN_EN
        step("rr0", 3'b010, 1, 30'd8,  0, 4'hF, 1, 0, 32'hA500_0008);
        step("rr1", 3'b100, 1, 30'd12, 0, 4'hF, 2, 0, 32'hA500_000C);
        step("rr2", 3'b010, 1, 30'd8,  0, 4'hF, 1, 0, 32'hA500_0008);
`else
        step("fx0", 3'b010, 1, 30'd8,  0, 4'hF, 1, 0, 32'hA500_0008);
        step("fx1", 3'b010, 1, 30'd8,  0, 4'hF, 1, 0, 32'hA500_0008);
        step("fx2", 3'b010, 1, 30'd8,  0, 4'hF, 1, 0, 32'hA500_0008);
`endif

        // Boot write overrides both.
        boot_req = 1; boot_we = 1; boot_be = 4'hF; boot_addr = 32'h0; boot_wdata = 32'h0000_0013;
        step("boot_wr", 3'b001, 1, 30'd0, 1, 4'hF, 0, 0, 32'h0);
        boot_req = 0; boot_we = 0;

        // Arbitration state must not have moved during the boot grant.
`ifdef ARB_ROUND_ROBIN_EN
        step("after_boot", 3'b100, 1, 30'd12, 0, 4'hF, 2, 0, 32'hA500_000C);
`else
        step("after_boot", 3'b010, 1, 30'd8,  0, 4'hF, 1, 0, 32'hA500_0008);
`endif
        instr_req = 0;

        // Read back the boot write.
        data_addr = 32'h0;
        step("rd_boot_word", 3'b010, 1, 30'd0, 0, 4'hF, 1, 0, 32'h0000_0013);

        // First address past the SRAM window.
        data_addr = 32'h0000_1000;
        step("out_of_range", 3'b010, 0, 30'd0, 0, 4'h0, 1, 1, 32'h0);

        // Partial write.
        data_we = 1; data_be = 4'b0010; data_wdata = 32'h0000_AB00; data_addr = 32'h8;
        step("byte_wr", 3'b010, 1, 30'd2, 1, 4'b0010, 1, 0, 32'h0);

        // Misaligned read of the same word, then a back-to-back read.
        data_we = 0; data_be = 4'hF; data_addr = 32'h0A;
        step("misaligned_rd", 3'b010, 1, 30'd2, 0, 4'hF, 1, 0, 32'hA500_AB02);
        data_addr = 32'h4;
        step("b2b_rd", 3'b010, 1, 30'd1, 0, 4'hF, 1, 0, 32'hA500_0001);
        data_req = 0;
        step("idle", 3'b000, 0, 30'd0, 0, 4'h0, -1, 0, 32'h0);

        // Reset lands in the cycle after an instr grant: response dropped.
        instr_req = 1; instr_addr = 32'h10;
        step("pre_rst_instr", 3'b100, 1, 30'd4, 0, 4'hF, -1, 0, 32'h0);
        Rst = 1; instr_req = 0; data_req = 1; data_addr = 32'h20;
        @(negedge Clk);
        chk("in_rst_gnt", 32'({instr_gnt, data_gnt, boot_gnt}), 32'h0);
        chk("in_rst_mem_req", 32'(mem_req), 32'h0);
        chk_quiet("in_rst");
        @(posedge Clk); #1;
        Rst = 0; data_req = 0;

        instr_req = 1; instr_addr = 32'h30;
        step("post_rst_instr", 3'b100, 1, 30'd12, 0, 4'hF, 2, 0, 32'hA500_000C);
        instr_req = 0;

        repeat (3) step("drain", 3'b000, 0, 30'd0, 0, 4'h0, -1, 0, 32'h0);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
